// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned NxN shift-and-add multiplier built on select_add_n.
// Define SHIFT_ADD_MULT_ZERO_SKIP_EN to finish zero-operand requests in one cycle.
module select_add_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int B = N / 4;
    logic [B:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < B; i++) begin : g
        logic [4:0] s0, s1;
        assign s0 = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]};
        assign s1 = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + 5'd1;
        assign sum[4*i+:4] = c[i] ? s1[3:0] : s0[3:0];
        assign c[i+1] = c[i] ? s1[4] : s0[4];
    end
    assign cout = c[B];
endmodule

module shift_add_mult #(
    parameter int N = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0] acc, acc_n, mq, mq_n, mcand, mcand_n, s;
    logic c;
    logic [CW-1:0] count, count_n;
    logic [2*N-1:0] product_n;
    select_add_n #(.N(N)) u_add (.a(acc), .b(mcand), .cin(1'b0), .sum(s), .cout(c));
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    logic zero;
    assign zero = (a == '0) || (b == '0);
`else
    localparam logic zero = 1'b0;
`endif
    assign busy = state == CALC;
    assign done = state == DONE;
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        mq_n      = mq;
        mcand_n   = mcand;
        count_n   = count;
        product_n = product;
        if (state == CALC) begin
            // adder carry-out becomes the new accumulator MSB
            {acc_n, mq_n} = mq[0] ? {c, s, mq[N-1:1]} : {1'b0, acc, mq[N-1:1]};
            count_n = count - CW'(1);
            if (count == CW'(1)) begin
                product_n = {acc_n, mq_n};
                state_n   = DONE;
            end
        end else if (start) begin
            mcand_n = a;
            mq_n    = b;
            acc_n   = '0;
            count_n = CW'(N);
            state_n = zero ? DONE : CALC;
            if (zero) product_n = '0;
        end else begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mq      <= mq_n;
            mcand   <= mcand_n;
            count   <= count_n;
            product <= product_n;
        end
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed checks of the shift-and-add multiplier handshake and results.
module tb_shift_add_mult;
    localparam int N = 32;
    logic clk = 0, rst_n = 0, start = 0;
    logic [N-1:0] a = '0, b = '0;
    logic busy, done;
    logic [2*N-1:0] product;
    int checks = 0, failures = 0;
    int at, nb;

    always #5 clk = ~clk;

    shift_add_mult #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    // call from a negedge; returns just after the accept edge
    task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y);
        start = 1; a = x; b = y;
        @(posedge clk);
        #1 start = 0; a = $urandom; b = $urandom;
    endtask

    // cycle k is sampled on the k-th negedge after the accept edge
    task automatic wait_done(input int poke, output int done_at, output int nbusy);
        done_at = 0; nbusy = 0;
        for (int k = 1; k <= 100 && done_at == 0; k++) begin
            @(negedge clk);
            nbusy += int'(busy);
            if (done) done_at = k;
            if (k == poke) begin start = 1; a = 1; b = 1; end
            if (k == poke + 1) start = 0;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b done=%b exp=0,0", busy, done); end
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        launch(3, 5);
        wait_done(0, at, nb);
        checks++; if (at !== 33) begin failures++; $display("FAIL basic_latency got=%0d exp=33", at); end
        checks++; if (nb !== 32) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=32", nb); end
        checks++; if (product !== 64'd15) begin failures++; $display("FAIL basic_product got=%h exp=%h", product, 64'd15); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        repeat (10) begin
            @(negedge clk);
            checks++; if (product !== 64'd15 || busy !== 1'b0) begin failures++; $display("FAIL basic_hold product=%h busy=%b exp=%h,0", product, busy, 64'd15); end
        end
    endtask

    task automatic test_max_carry;
        @(negedge clk);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, at, nb);
        checks++; if (product !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL max_product got=%h exp=%h", product, 64'hFFFF_FFFE_0000_0001); end
        checks++; if (at !== 33) begin failures++; $display("FAIL max_latency got=%0d exp=33", at); end
        @(negedge clk);
        launch(32'h8000_0000, 32'd2);
        wait_done(0, at, nb);
        checks++; if (product !== 64'h1_0000_0000) begin failures++; $display("FAIL carry_product got=%h exp=%h", product, 64'h1_0000_0000); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        launch(7, 9);
        wait_done(5, at, nb);
        checks++; if (product !== 64'd63) begin failures++; $display("FAIL ignore_product got=%h exp=%h", product, 64'd63); end
        checks++; if (at !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", at); end
        launch(2, 4);
        checks++; if (product !== 64'd63 || busy !== 1'b1) begin failures++; $display("FAIL b2b_accept product=%h busy=%b exp=%h,1", product, busy, 64'd63); end
        wait_done(0, at, nb);
        checks++; if (product !== 64'd8) begin failures++; $display("FAIL b2b_product got=%h exp=%h", product, 64'd8); end
        checks++; if (at !== 33 || nb !== 32) begin failures++; $display("FAIL b2b_timing done_at=%0d busy=%0d exp=33,32", at, nb); end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        @(negedge clk);
        launch(6, 7);
        repeat (10) @(negedge clk);
        rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_ctrl busy=%b done=%b exp=0,0", busy, done); end
        checks++; if (product !== '0) begin failures++; $display("FAIL midreset_product got=%h exp=0", product); end
        @(negedge clk);
        rst_n = 1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_abort got=%b exp=0", seen); end
        launch(6, 7);
        wait_done(0, at, nb);
        checks++; if (product !== 64'd42 || at !== 33) begin failures++; $display("FAIL midreset_restart product=%h done_at=%0d exp=%h,33", product, at, 64'd42); end
    endtask

    task automatic test_zero;
        @(negedge clk);
        launch(0, 123);
        wait_done(0, at, nb);
        checks++; if (product !== '0) begin failures++; $display("FAIL zero_product got=%h exp=0", product); end
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
        checks++; if (at !== 1 || nb !== 0) begin failures++; $display("FAIL zero_skip done_at=%0d busy=%0d exp=1,0", at, nb); end
`else
        checks++; if (at !== 33 || nb !== 32) begin failures++; $display("FAIL zero_latency done_at=%0d busy=%0d exp=33,32", at, nb); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max_carry;
        test_back_to_back;
        test_reset_mid;
        test_zero;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
